sig_gen_voice_alloc: RTL and testbench

- Voice allocator and scheduler for the sig_gen wave-generator bank.
- Consumes note-on/note-off events over a valid/ready handshake and tracks which of WAVE_CNT generators holds which note.
- Programs the selected generator by driving sig_gen's frequency/amplitude/extra/mask write interface for exactly one cycle.
- Steals the oldest voice when every generator is busy.

---
 rtl/sig_gen_voice_alloc_if.sv | 21 ++
 rtl/sig_gen_voice_alloc.sv | 175 +++++++++++++++++
 tb/tb_sig_gen_voice_alloc.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_gen_voice_alloc_if.sv
// Note event channel into the voice allocator: valid/ready handshake plus
// the note-on/note-off payload.
interface sig_gen_voice_alloc_if;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [31:0] ev_freq;
  logic [31:0] ev_amp;
  logic [31:0] ev_extra;

  modport master (
    output ev_valid, ev_on, ev_note, ev_freq, ev_amp, ev_extra,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_freq, ev_amp, ev_extra,
    output ev_ready
  );
endinterface

// File: rtl/sig_gen_voice_alloc.sv
// Voice allocator for the sig_gen bank: maps note events onto generators,
// steals the oldest voice when the bank is full, and programs sig_gen.
//
// state  | meaning
// IDLE   | waiting for an event or all_off
// LOOKUP | pick target voice from the table and the latched event
// WRITE  | write pulse on mask, table updated at the end of the cycle
// CLR    | one silencing write per busy voice, ascending index
module sig_gen_voice_alloc #(
  parameter int WAVE_CNT = 4,
  parameter int AGE_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  sig_gen_voice_alloc_if.slave ev,
  input  logic                all_off,
  output logic [31:0]         frequency,
  output logic [31:0]         amplitude,
  output logic [31:0]         extra,
  output logic [31:0]         mask,
  output logic [WAVE_CNT-1:0] voices_busy,
  output logic                steal
);

  localparam int VW = (WAVE_CNT > 1) ? $clog2(WAVE_CNT) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, CLR} state_t;

  state_t              state;
  logic [WAVE_CNT-1:0] busy;
  logic [6:0]          note_q [WAVE_CNT];
  logic [AGE_W-1:0]    age_q  [WAVE_CNT];
  logic [VW-1:0]       tgt;

  logic        lat_on;
  logic [6:0]  lat_note;
  logic [31:0] lat_freq;
  logic [31:0] lat_amp;
  logic [31:0] lat_extra;

  logic                hit_found, free_found, clr_found;
  logic [VW-1:0]       hit_v, free_v, old_v, on_v, clr_v;
  logic [AGE_W-1:0]    old_age;
  logic [WAVE_CNT-1:0] clr_cand;

  assign ev.ev_ready  = (state == IDLE) && !all_off && !rst;
  assign voices_busy  = busy;

  // Oldest-voice search uses strict '>' so ties resolve to the lowest index.
  always_comb begin
    hit_found  = 1'b0;
    hit_v      = '0;
    free_found = 1'b0;
    free_v     = '0;
    old_v      = '0;
    old_age    = '0;
    for (int i = 0; i < WAVE_CNT; i++) begin
      if (busy[i] && (note_q[i] == lat_note) && !hit_found) begin
        hit_found = 1'b1;
        hit_v     = VW'(i);
      end
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_v     = VW'(i);
      end
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_v   = VW'(i);
      end
    end
    on_v = hit_found ? hit_v : (free_found ? free_v : old_v);
  end

  // During CLR the voice currently on the bus is excluded; its busy bit
  // drops at the end of its write cycle.
  always_comb begin
    clr_cand  = busy & ~mask[WAVE_CNT-1:0];
    clr_found = 1'b0;
    clr_v     = '0;
    for (int i = 0; i < WAVE_CNT; i++) begin
      if (clr_cand[i] && !clr_found) begin
        clr_found = 1'b1;
        clr_v     = VW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= '0;
      tgt       <= '0;
      lat_on    <= 1'b0;
      lat_note  <= '0;
      lat_freq  <= '0;
      lat_amp   <= '0;
      lat_extra <= '0;
      frequency <= '0;
      amplitude <= '0;
      extra     <= '0;
      mask      <= '0;
      steal     <= 1'b0;
      for (int i = 0; i < WAVE_CNT; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (all_off) begin
            state <= CLR;
          end else if (ev.ev_valid) begin
            lat_on    <= ev.ev_on;
            lat_note  <= ev.ev_note;
            lat_freq  <= ev.ev_freq;
            lat_amp   <= ev.ev_amp;
            lat_extra <= ev.ev_extra;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lat_on) begin
            tgt       <= on_v;
            mask      <= 32'd1 << on_v;
            frequency <= lat_freq;
            amplitude <= lat_amp;
            extra     <= lat_extra;
            steal     <= !hit_found && !free_found;
            state     <= WRITE;
          end else if (hit_found) begin
            tgt       <= hit_v;
            mask      <= 32'd1 << hit_v;
            frequency <= '0;
            amplitude <= '0;
            extra     <= '0;
            state     <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          mask  <= '0;
          steal <= 1'b0;
          state <= IDLE;
          for (int i = 0; i < WAVE_CNT; i++) begin
            if (VW'(i) == tgt) begin
              busy[i]  <= lat_on;
              age_q[i] <= '0;
              if (lat_on) note_q[i] <= lat_note;
            end else if (lat_on && busy[i] && (age_q[i] != {AGE_W{1'b1}})) begin
              age_q[i] <= age_q[i] + 1'b1;
            end
          end
        end
        CLR: begin
          busy <= busy & ~mask[WAVE_CNT-1:0];
          for (int i = 0; i < WAVE_CNT; i++) begin
            if (mask[i]) age_q[i] <= '0;
          end
          if (clr_found) begin
            mask      <= 32'd1 << clr_v;
            frequency <= '0;
            amplitude <= '0;
            extra     <= '0;
          end else begin
            mask  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_gen_voice_alloc.sv
// Scoreboard bench for sig_gen_voice_alloc: a reference voice table predicts
// each write, a negedge monitor checks every nonzero mask against it.
module tb_sig_gen_voice_alloc;
  localparam int WC = 4;
  localparam int AMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          all_off = 1'b0;
  logic [31:0]   frequency, amplitude, extra, mask;
  logic [WC-1:0] voices_busy;
  logic          steal;

  sig_gen_voice_alloc_if evif ();

  sig_gen_voice_alloc #(.WAVE_CNT(WC), .AGE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev         (evif),
    .all_off    (all_off),
    .frequency  (frequency),
    .amplitude  (amplitude),
    .extra      (extra),
    .mask       (mask),
    .voices_busy(voices_busy),
    .steal      (steal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] freq;
    logic [31:0] amp;
    logic [31:0] extra;
    logic        steal;
    int          due;
  } wr_t;

  wr_t q[$];
  int  nvec = 0;
  int  nerr = 0;

  int m_busy[WC];
  int m_note[WC];
  int m_age[WC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WC-1:0] model_busy();
    logic [WC-1:0] b;
    b = '0;
    for (int i = 0; i < WC; i++) b[i] = (m_busy[i] != 0);
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < WC; i++) begin
      m_busy[i] = 0;
      m_note[i] = 0;
      m_age[i]  = 0;
    end
  endfunction

  // Reference allocation: retrigger, else first free, else the voice that has
  // gone longest without being (re)triggered (saturating age, lowest index on tie).
  task automatic model_ev(input bit on, input int note, input logic [31:0] f,
                          input logic [31:0] a, input logic [31:0] x, input int acc,
                          output bit wrote);
    int  hit, v, best;
    bit  st;
    wr_t w;
    hit = -1;
    for (int i = 0; i < WC; i++)
      if (hit < 0 && m_busy[i] != 0 && m_note[i] == note) hit = i;
    wrote = 1'b0;
    st    = 1'b0;
    v     = -1;
    if (on) begin
      if (hit >= 0) v = hit;
      else begin
        for (int i = 0; i < WC; i++) if (v < 0 && m_busy[i] == 0) v = i;
        if (v < 0) begin
          st = 1'b1;
          best = -1;
          for (int i = 0; i < WC; i++)
            if (m_age[i] > best) begin best = m_age[i]; v = i; end
        end
      end
      w.mask = 32'd1 << v; w.freq = f; w.amp = a; w.extra = x;
      w.steal = st; w.due = acc + 1;
      q.push_back(w);
      for (int i = 0; i < WC; i++)
        if (i != v && m_busy[i] != 0 && m_age[i] < AMAX) m_age[i]++;
      m_busy[v] = 1; m_note[v] = note; m_age[v] = 0;
      wrote = 1'b1;
    end else if (hit >= 0) begin
      w.mask = 32'd1 << hit; w.freq = '0; w.amp = '0; w.extra = '0;
      w.steal = 1'b0; w.due = acc + 1;
      q.push_back(w);
      m_busy[hit] = 0; m_age[hit] = 0;
      wrote = 1'b1;
    end
  endtask

  task automatic accept(input bit on, input int note, input logic [31:0] f,
                        input logic [31:0] a, input logic [31:0] x, output int acc);
    int budget;
    acc = -1;
    @(negedge clk);
    evif.ev_valid = 1'b1; evif.ev_on = on; evif.ev_note = 7'(note);
    evif.ev_freq = f; evif.ev_amp = a; evif.ev_extra = x;
    budget = 0;
    while (!evif.ev_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!evif.ev_ready) begin
      nvec++; nerr++;
      $display("FAIL ready_timeout: ev_ready stayed %b, wanted 1", evif.ev_ready);
      evif.ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 acc = cyc;
    // Payload changes after the handshake must not reach the write.
    evif.ev_valid = 1'b0; evif.ev_on = 1'($urandom); evif.ev_note = 7'($urandom);
    evif.ev_freq = $urandom; evif.ev_amp = $urandom; evif.ev_extra = $urandom;
  endtask

  task automatic send(input bit on, input int note, input logic [31:0] f,
                      input logic [31:0] a, input logic [31:0] x);
    int acc;
    bit wrote;
    accept(on, note, f, a, x, acc);
    if (acc < 0) return;
    model_ev(on, note, f, a, x, acc, wrote);
    @(negedge clk);
    chk("ready_lookup", 32'(evif.ev_ready), 32'd0);
    @(negedge clk);
    chk("ready_post_lookup", 32'(evif.ev_ready), wrote ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("voices_busy", 32'(voices_busy), 32'(model_busy()));
    chk("ready_idle", 32'(evif.ev_ready), 32'd1);
  endtask

  task automatic do_all_off();
    int  acc, n, budget;
    wr_t w;
    @(negedge clk);
    budget = 0;
    while (!evif.ev_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    all_off = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    all_off = 1'b0;
    n = 0;
    for (int i = 0; i < WC; i++) begin
      if (m_busy[i] != 0) begin
        w.mask = 32'd1 << i; w.freq = '0; w.amp = '0; w.extra = '0;
        w.steal = 1'b0; w.due = acc + 1 + n;
        q.push_back(w);
        m_busy[i] = 0; m_age[i] = 0;
        n++;
      end
    end
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      chk("ready_in_clr", 32'(evif.ev_ready), 32'd0);
    end
    @(negedge clk);
    chk("ready_after_clr", 32'(evif.ev_ready), 32'd1);
    chk("busy_after_clr", 32'(voices_busy), 32'd0);
  endtask

  task automatic reset_mid();
    int acc;
    accept(1'b1, 61, 32'h0000_0777, 32'h1, 32'h2, acc);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_clear();
    #1;
    chk("rst_mask", mask, 32'd0);
    chk("rst_busy", 32'(voices_busy), 32'd0);
    chk("rst_ready", 32'(evif.ev_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(evif.ev_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("no_write_after_rst", mask, 32'd0);
  endtask

  // Monitor: every nonzero mask must match the oldest pending prediction.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mask !== 32'd0) begin
          if (q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_write: mask %h, no write pending", mask);
          end else begin
            e = q.pop_front();
            chk("wr_mask", mask, e.mask);
            chk("wr_freq", frequency, e.freq);
            chk("wr_amp", amplitude, e.amp);
            chk("wr_extra", extra, e.extra);
            chk("wr_steal", 32'(steal), 32'(e.steal));
            chk("wr_cycle", 32'(cyc), 32'(e.due));
          end
        end else begin
          chk("steal_idle", 32'(steal), 32'd0);
        end
      end
    end
  end

  initial begin
    evif.ev_valid = 1'b0; evif.ev_on = 1'b0; evif.ev_note = '0;
    evif.ev_freq = '0; evif.ev_amp = '0; evif.ev_extra = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_mask", mask, 32'd0);
    chk("reset_freq", frequency, 32'd0);
    chk("reset_busy", 32'(voices_busy), 32'd0);
    chk("reset_steal", 32'(steal), 32'd0);
    chk("reset_ready", 32'(evif.ev_ready), 32'd0);
    rst = 1'b0;

    send(1'b1, 60, 32'h100, 32'h1000, 32'h10);
    send(1'b1, 62, 32'h200, 32'h2000, 32'h20);
    send(1'b1, 64, 32'h300, 32'h3000, 32'h30);
    send(1'b1, 65, 32'h400, 32'h4000, 32'h40);
    chk("full_bank", 32'(voices_busy), 32'hF);
    send(1'b1, 67, 32'h500, 32'h5000, 32'h50);
    chk("after_steal", 32'(voices_busy), 32'hF);
    send(1'b0, 64, 32'hdead, 32'hbeef, 32'h1);
    chk("after_off64", 32'(voices_busy), 32'hB);
    send(1'b1, 70, 32'h700, 32'h7000, 32'h70);
    send(1'b1, 62, 32'h222, 32'h2220, 32'h22);
    chk("after_retrig", 32'(voices_busy), 32'hF);
    send(1'b0, 50, 32'h0, 32'h0, 32'h0);
    send(1'b0, 62, 32'h0, 32'h0, 32'h0);
    chk("before_all_off", 32'(voices_busy), 32'hD);
    do_all_off();
    do_all_off();

    send(1'b1, 66, 32'h600, 32'h6000, 32'h60);
    reset_mid();

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 11) == 0) do_all_off();
      else send($urandom_range(0, 9) < 6, 60 + $urandom_range(0, 7),
                $urandom, $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
